// File: rtl/wb_branch_unit.sv
// Writeback and control-transfer stage: drives the register-file write port,
// resolves branches/jumps, owns the PC and squashes wrong-path instructions.
module wb_branch_unit #(
    parameter int unsigned FLUSH_DEPTH = 3,
    parameter logic [31:0] PC_RESET    = 32'h0,
    parameter logic [31:0] PC_STEP     = 32'h1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] alu_in,
    input  logic [31:0] data_mem_in,
    input  logic [31:0] addr_in,
    input  logic [5:0]  rd_in,
    input  logic        n_in,
    input  logic        z_in,
    input  logic        reg_write_in,
    input  logic        memtoreg_in,
    input  logic        pctoreg_in,
    input  logic        branch_neg_in,
    input  logic        branch_z_in,
    input  logic        jump_in,
    input  logic        jump_mem_in,
    output logic [31:0] pc_out,
    output logic        rf_we,
    output logic [5:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] retire_count
);

    localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_DEPTH);

    typedef enum logic {
        S_RUN,
        S_SQUASH
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  squash_cnt_q, squash_cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retire_q, retire_d;
    logic        ivalid;
    logic        taken;
    logic [31:0] target;

    assign ivalid = (state_q == S_RUN) && !reset;

    assign rf_wa = rd_in;
    assign rf_wd = pctoreg_in ? addr_in : (memtoreg_in ? data_mem_in : alu_in);
    assign rf_we = ivalid && reg_write_in;

    // Fixed priority: jump_mem > jump > branch_z > branch_neg.
    always_comb begin
        taken  = 1'b0;
        target = addr_in;
        if (jump_mem_in) begin
            taken  = 1'b1;
            target = data_mem_in;
        end else if (jump_in) begin
            taken  = 1'b1;
        end else if (branch_z_in && z_in) begin
            taken  = 1'b1;
        end else if (branch_neg_in && n_in) begin
            taken  = 1'b1;
        end
    end

    assign redirect = ivalid && taken;

    always_comb begin
        state_d      = state_q;
        squash_cnt_d = squash_cnt_q;
        case (state_q)
            S_RUN: begin
                if (redirect) begin
                    squash_cnt_d = FLUSH_CNT;
                    state_d      = S_SQUASH;
                end
            end
            S_SQUASH: begin
                if (!stall) begin
                    squash_cnt_d = squash_cnt_q - 3'd1;
                    state_d      = (squash_cnt_q == 3'd1) ? S_RUN : S_SQUASH;
                end
            end
            default: begin
                state_d      = S_RUN;
                squash_cnt_d = 3'd0;
            end
        endcase
    end

    // A redirect wins over stall so the target is never lost.
    always_comb begin
        pc_d = pc_q + PC_STEP;
        if (redirect) begin
            pc_d = target;
        end else if (stall) begin
            pc_d = pc_q;
        end
        retire_d = retire_q;
        if (ivalid && !stall) begin
            retire_d = retire_q + 32'd1;
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state_q      <= S_RUN;
            squash_cnt_q <= 3'd0;
            pc_q         <= PC_RESET;
            retire_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            squash_cnt_q <= squash_cnt_d;
            pc_q         <= pc_d;
            retire_q     <= retire_d;
        end
    end

    assign pc_out       = pc_q;
    assign flush        = (state_q == S_SQUASH);
    assign retire_count = retire_q;

endmodule

// File: tb/tb_wb_branch_unit.sv
// Scoreboard bench for wb_branch_unit: directed vectors push expectations,
// a monitor pops and compares at every rising edge (state moves on falling).
module tb_wb_branch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] alu_in = '0, data_mem_in = '0, addr_in = '0;
    logic [5:0]  rd_in = '0;
    logic        n_in = 1'b0, z_in = 1'b0;
    logic        reg_write_in = 1'b0, memtoreg_in = 1'b0, pctoreg_in = 1'b0;
    logic        branch_neg_in = 1'b0, branch_z_in = 1'b0, jump_in = 1'b0, jump_mem_in = 1'b0;
    logic [31:0] pc_out, rf_wd, retire_count;
    logic [5:0]  rf_wa;
    logic        rf_we, flush, redirect;

    wb_branch_unit #(.FLUSH_DEPTH(3), .PC_RESET(32'h0), .PC_STEP(32'h1)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .alu_in(alu_in), .data_mem_in(data_mem_in), .addr_in(addr_in), .rd_in(rd_in),
        .n_in(n_in), .z_in(z_in),
        .reg_write_in(reg_write_in), .memtoreg_in(memtoreg_in), .pctoreg_in(pctoreg_in),
        .branch_neg_in(branch_neg_in), .branch_z_in(branch_z_in),
        .jump_in(jump_in), .jump_mem_in(jump_mem_in),
        .pc_out(pc_out), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .flush(flush), .redirect(redirect), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    localparam logic [10:0] RST = 11'h400, STL = 11'h200, N = 11'h100, Z = 11'h080;
    localparam logic [10:0] RW = 11'h040, M2R = 11'h020, P2R = 11'h010, BN = 11'h008;
    localparam logic [10:0] BZ = 11'h004, J = 11'h002, JM = 11'h001, NONE = 11'h000;

    typedef struct {
        logic [31:0] pc;
        logic        fl;
        logic [31:0] rt;
        logic        we;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic        rdr;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
        end
    endtask

    // Drive one cycle of inputs after the falling edge and record what the
    // outputs must show before the next falling edge.
    task automatic step(input logic [10:0] c, input logic [31:0] alu, input logic [31:0] dmem,
                        input logic [31:0] addr, input logic [5:0] rd,
                        input logic [31:0] epc, input logic efl, input logic [31:0] ert,
                        input logic ewe, input logic [31:0] ewd, input logic erdr);
        exp_t e;
        @(negedge clk);
        #1;
        reset = c[10]; stall = c[9]; n_in = c[8]; z_in = c[7];
        reg_write_in = c[6]; memtoreg_in = c[5]; pctoreg_in = c[4];
        branch_neg_in = c[3]; branch_z_in = c[2]; jump_in = c[1]; jump_mem_in = c[0];
        alu_in = alu; data_mem_in = dmem; addr_in = addr; rd_in = rd;
        e.pc = epc; e.fl = efl; e.rt = ert; e.we = ewe; e.wa = rd; e.wd = ewd; e.rdr = erdr;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_out", pc_out, e.pc);
                chk("flush", 32'(flush), 32'(e.fl));
                chk("retire_count", retire_count, e.rt);
                chk("rf_we", 32'(rf_we), 32'(e.we));
                chk("rf_wa", 32'(rf_wa), 32'(e.wa));
                chk("rf_wd", rf_wd, e.wd);
                chk("redirect", 32'(redirect), 32'(e.rdr));
            end
        end
    end

    initial begin : stim
        int budget;
        repeat (2) @(negedge clk);
        //    ctrl           alu    dmem          addr   rd  pc      fl rt  we wd            rdr
        step(RST | RW,       32'h0, 32'h0,        32'h0, 0,  32'h0,  0, 0,  0, 32'h0,        0);
        step(NONE,           32'h0, 32'h0,        32'h0, 0,  32'h0,  0, 0,  0, 32'h0,        0);
        step(NONE,           32'h0, 32'h0,        32'h0, 0,  32'h1,  0, 1,  0, 32'h0,        0);
        step(NONE,           32'h0, 32'h0,        32'h0, 0,  32'h2,  0, 2,  0, 32'h0,        0);
        step(NONE,           32'h0, 32'h0,        32'h0, 0,  32'h3,  0, 3,  0, 32'h0,        0);
        step(RW | M2R,       32'h0, 32'hDEADBEEF, 32'h0, 5,  32'h4,  0, 4,  1, 32'hDEADBEEF, 0);
        step(RW | M2R | P2R, 32'h0, 32'hDEADBEEF, 32'h40,5,  32'h5,  0, 5,  1, 32'h40,       0);
        step(NONE,           32'h0, 32'h0,        32'h0, 0,  32'h6,  0, 6,  0, 32'h0,        0);
        step(NONE,           32'h0, 32'h0,        32'h0, 0,  32'h7,  0, 7,  0, 32'h0,        0);
        step(BZ | Z,         32'h0, 32'h0,        32'h100,0, 32'h8,  0, 8,  0, 32'h0,        1);
        step(RW,             32'h7, 32'h0,        32'h0, 3,  32'h100,1, 9,  0, 32'h7,        0);
        step(RW | J,         32'h0, 32'h0,        32'h300,0, 32'h101,1, 9,  0, 32'h0,        0);
        step(RW,             32'h0, 32'h0,        32'h0, 0,  32'h102,1, 9,  0, 32'h0,        0);
        step(NONE,           32'h0, 32'h0,        32'h0, 0,  32'h103,0, 9,  0, 32'h0,        0);
        step(BN,             32'h0, 32'h0,        32'h500,0, 32'h104,0, 10, 0, 32'h0,        0);
        step(JM | J,         32'h0, 32'h200,      32'h300,0, 32'h105,0, 11, 0, 32'h0,        1);
        step(NONE,           32'h0, 32'h0,        32'h0, 0,  32'h200,1, 12, 0, 32'h0,        0);
        step(NONE,           32'h0, 32'h0,        32'h0, 0,  32'h201,1, 12, 0, 32'h0,        0);
        step(NONE,           32'h0, 32'h0,        32'h0, 0,  32'h202,1, 12, 0, 32'h0,        0);
        step(NONE,           32'h0, 32'h0,        32'h0, 0,  32'h203,0, 12, 0, 32'h0,        0);
        step(J,              32'h0, 32'h0,        32'h40,0,  32'h204,0, 13, 0, 32'h0,        1);
        step(NONE,           32'h0, 32'h0,        32'h0, 0,  32'h40, 1, 14, 0, 32'h0,        0);
        step(STL,            32'h0, 32'h0,        32'h0, 0,  32'h41, 1, 14, 0, 32'h0,        0);
        step(STL,            32'h0, 32'h0,        32'h0, 0,  32'h41, 1, 14, 0, 32'h0,        0);
        step(NONE,           32'h0, 32'h0,        32'h0, 0,  32'h41, 1, 14, 0, 32'h0,        0);
        step(NONE,           32'h0, 32'h0,        32'h0, 0,  32'h42, 1, 14, 0, 32'h0,        0);
        step(NONE,           32'h0, 32'h0,        32'h0, 0,  32'h43, 0, 14, 0, 32'h0,        0);
        step(STL | J,        32'h0, 32'h0,        32'h80,0,  32'h44, 0, 15, 0, 32'h0,        1);
        step(STL,            32'h0, 32'h0,        32'h0, 0,  32'h80, 1, 15, 0, 32'h0,        0);
        step(NONE,           32'h0, 32'h0,        32'h0, 0,  32'h80, 1, 15, 0, 32'h0,        0);
        step(RST | RW | J,   32'h0, 32'h0,        32'h90,0,  32'h81, 1, 15, 0, 32'h0,        0);
        step(NONE,           32'h0, 32'h0,        32'h0, 0,  32'h0,  0, 0,  0, 32'h0,        0);
        step(BN | N,         32'h0, 32'h0,        32'h20,0,  32'h1,  0, 1,  0, 32'h0,        1);
        step(NONE,           32'h0, 32'h0,        32'h0, 0,  32'h20, 1, 2,  0, 32'h0,        0);
        budget = 10;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_branch_unit.md
# wb_branch_unit

Writeback and control-transfer unit at the consumer end of the EX/WB pipeline register. It takes the latched EX/WB fields and drives the register-file write port. It resolves branches and jumps, owns the program counter, and squashes the wrong-path instructions that follow a taken redirect. It is the final pipeline stage and closes the loop back to instruction fetch.

## Interface
Parameters:
- FLUSH_DEPTH, 3: number of younger instructions in flight behind EX/WB that must be squashed after a redirect (range 1–7).
- PC_RESET, 32'h0: PC value loaded on reset.
- PC_STEP, 1: sequential PC increment (word-addressed instruction memory).

Ports:
- clk  in  1  system clock; all state updates on the falling edge, matching the pipeline registers
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard stall from decode; holds PC and squash counter
- alu_in  in  32  ALU result from EX/WB
- data_mem_in  in  32  data-memory read value from EX/WB
- addr_in  in  32  branch/jump target and link value from EX/WB
- rd_in  in  6  destination register
- n_in, z_in  in  1 each  negative / zero flags
- reg_write_in, memtoreg_in, pctoreg_in  in  1 each  writeback controls
- branch_neg_in, branch_z_in, jump_in, jump_mem_in  in  1 each  control-transfer controls
- pc_out  out  32  current fetch PC (registered)
- rf_we  out  1  register-file write enable (combinational)
- rf_wa  out  6  register-file write address (combinational, = rd_in)
- rf_wd  out  32  register-file write data (combinational)
- flush  out  1  high while the squash counter is non-zero; IF/ID, ID/EX and EX/WB treat their contents as bubbles
- redirect  out  1  pulses for the cycle in which a taken transfer is accepted (combinational)
- retire_count  out  32  count of non-squashed, non-stalled instructions consumed

## Operation
- Instruction valid: `ivalid = (squash_cnt == 0) && !reset`.
- Write data: `rf_wd = pctoreg_in ? addr_in : (memtoreg_in ? data_mem_in : alu_in)`.
- Write enable: `rf_we = ivalid && reg_write_in`.
- Taken detection uses fixed priority jump_mem > jump > branch_z > branch_neg:
  - jump_mem_in: target = data_mem_in.
  - jump_in: target = addr_in.
  - branch_z_in && z_in: target = addr_in.
  - branch_neg_in && n_in: target = addr_in.
- `redirect = ivalid && taken`.
- Squash counter `squash_cnt` (3 bits) acts as a two-state control:
  - RUN (cnt = 0): on redirect, load FLUSH_DEPTH.
  - SQUASH (cnt > 0): decrement when stall = 0. Control fields are ignored, so a branch in a squashed slot never redirects.
- PC update, by priority:
  1. reset → PC_RESET.
  2. redirect → target. Redirect overrides stall.
  3. stall → hold.
  4. otherwise → pc + PC_STEP, wrapping modulo 2^32.
- retire_count increments when `ivalid && !stall`, wrapping at 2^32. A redirecting instruction counts as retired.
- Flags n_in/z_in are used as latched alongside the instruction; the unit keeps no flag state of its own.

## Timing
- Reset values: pc_out = PC_RESET, squash_cnt = 0, flush = 0, retire_count = 0. rf_we and redirect are forced to 0 while reset is high.
- Reset has priority over every other event, including mid-squash and during stall.
- Redirect latency: a taken transfer seen before falling edge k gives pc_out = target after edge k.
- Flush timing: flush rises after edge k and stays high for exactly FLUSH_DEPTH unstalled cycles.
- Squash and stall: stall cycles inside SQUASH extend the flush window one-for-one.
- Write timing: rf_we/rf_wa/rf_wd are valid for the whole cycle before the edge. A write and a redirect from the same instruction both occur (link write plus jump).
- Redirect under stall: PC loads the target and squash_cnt loads FLUSH_DEPTH in the same edge; the stall does not block either update.
- Consecutive transfers: a second taken transfer arriving inside the squash window is ignored.

## Test plan
- Reset, then 4 unstalled cycles with no controls → pc_out sequence 0,1,2,3,4; retire_count = 4; rf_we = 0 throughout.
- Instruction with reg_write_in = 1, memtoreg_in = 1, rd_in = 6'd5, data_mem_in = 32'hDEADBEEF → rf_we = 1, rf_wa = 5, rf_wd = 32'hDEADBEEF. With pctoreg_in = 1 and addr_in = 32'h40, rf_wd = 32'h40.
- branch_z_in = 1, z_in = 1, addr_in = 32'h100 at pc = 8:
  - Next pc_out = 32'h100; flush is high for 3 cycles.
  - reg_write_in driven high during those 3 cycles → rf_we stays 0.
  - A jump_in presented in the second squashed cycle → no redirect.
- branch_neg_in = 1 with n_in = 0 → no redirect; pc increments. Then jump_mem_in = 1 and jump_in = 1 together, data_mem_in = 32'h200, addr_in = 32'h300 → pc_out = 32'h200.
- Squash with stall: redirect, then stall for 2 cycles inside the window → flush lasts 5 cycles and PC is held during the stall. Separately, jump_in with stall = 1 → PC loads the target despite the stall.
- Reset asserted mid-squash (squash_cnt = 2) → after the edge, pc_out = PC_RESET, flush = 0, retire_count = 0.
